// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default operand width for the shift-add multiplier.
package mult_pkg;
  localparam int MULT_N = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_e;
endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: requester/shift-register side signals of the multiplier control stage.
interface shift_add_mult_ctrl_if import mult_pkg::*; #(parameter int N = MULT_N);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   shifted_multiplier;
  logic           sr_load;
  logic           sr_en;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;
  modport master (output start, multiplicand, shifted_multiplier,
                  input sr_load, sr_en, product, busy, done);
  modport slave  (input start, multiplicand, shifted_multiplier,
                  output sr_load, sr_en, product, busy, done);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: FSM, iteration counter and accumulator consuming one multiplier bit per cycle.
module shift_add_mult_ctrl import mult_pkg::*; #(
  parameter int N = MULT_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_mult_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);
  state_e         state_q, state_d;
  logic [2*N-1:0] product_q, product_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [CW-1:0]  count_q, count_d;
  logic           last;
  assign last = count_q == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      product_q <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    product_d   = product_q;
    mcand_d     = mcand_q;
    count_d     = count_q;
    bus.sr_load = 1'b0;
    bus.sr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.sr_load = bus.start;
        if (bus.start) begin
          mcand_d   = {{N{1'b0}}, bus.multiplicand};
          product_d = '0;
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // remaining multiplier bits all zero: nothing more to add
        if (bus.shifted_multiplier == '0) begin
          state_d = DONE;
        end else begin
          bus.sr_en = 1'b1;
          product_d = bus.shifted_multiplier[0] ? product_q + mcand_q : product_q;
          mcand_d   = mcand_q << 1;
          count_d   = last ? count_q : count_q + 1'b1;
          state_d   = last ? DONE : RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.product = product_q;
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = state_q == DONE;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed vectors against the control stage with a behavioural right-shift register.
module tb_shift_add_mult_ctrl;
  import mult_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mp_val = '0;
  logic [7:0] sr_q;
  int         n_checks = 0;
  int         n_errors = 0;
  shift_add_mult_ctrl_if #(.N(8)) bus ();
  shift_add_mult_ctrl #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else if (bus.sr_load) sr_q <= mp_val;
    else if (bus.sr_en) sr_q <= sr_q >> 1;
  end
  assign bus.shifted_multiplier = sr_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  // cycle c after the accepting edge T is sampled 1 time unit after edge T+c-1
  task automatic do_mult(input logic [7:0] mc, input logic [7:0] mp, input bit spam,
                         output int lat, output int ndone, output int nen, output int bad);
    @(negedge clk);
    bus.multiplicand = mc;
    mp_val = mp;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!spam) bus.start = 1'b0;
    lat = 0; ndone = 0; nen = 0; bad = 0;
    for (int c = 1; c <= 14; c++) begin
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = c;
        bus.start = 1'b0;
      end
      if (bus.sr_en) nen++;
      if (bus.sr_load && (bus.busy || bus.sr_en)) bad++;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask
  initial begin
    int lat, ndone, nen, bad;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    #12;
    check("reset_product", 32'(bus.product), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_sr_load", 32'(bus.sr_load), 0);
    check("reset_sr_en", 32'(bus.sr_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_mult(8'd13, 8'd11, 1'b0, lat, ndone, nen, bad);
    check("13x11_product", 32'(bus.product), 143);
    check("13x11_done_pulses", ndone, 1);
    check("13x11_latency", lat, 6);
    check("13x11_sr_en_cycles", nen, 4);
    do_mult(8'd255, 8'd255, 1'b0, lat, ndone, nen, bad);
    check("255x255_product", 32'(bus.product), 32'hFE01);
    check("255x255_latency", lat, 9);
    check("255x255_sr_en_cycles", nen, 8);
    check("255x255_done_pulses", ndone, 1);
    do_mult(8'd99, 8'd0, 1'b0, lat, ndone, nen, bad);
    check("mp0_product", 32'(bus.product), 0);
    check("mp0_latency", lat, 2);
    check("mp0_sr_en_cycles", nen, 0);
    do_mult(8'd200, 8'd1, 1'b0, lat, ndone, nen, bad);
    check("mp1_product", 32'(bus.product), 200);
    check("mp1_latency", lat, 3);
    check("mp1_sr_en_cycles", nen, 1);
    repeat (3) @(posedge clk);
    #1;
    check("idle_product_held", 32'(bus.product), 200);
    check("idle_busy", 32'(bus.busy), 0);
    do_mult(8'd255, 8'd255, 1'b1, lat, ndone, nen, bad);
    check("spam_product", 32'(bus.product), 32'hFE01);
    check("spam_done_pulses", ndone, 1);
    check("spam_latency", lat, 9);
    check("spam_load_while_busy", bad, 0);
    @(negedge clk);
    bus.multiplicand = 8'd255;
    mp_val = 8'd255;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_abort_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_product", 32'(bus.product), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_sr_en", 32'(bus.sr_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_mult(8'd7, 8'd6, 1'b0, lat, ndone, nen, bad);
    check("7x6_product", 32'(bus.product), 42);
    check("7x6_latency", lat, 5);
    check("7x6_done_pulses", ndone, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
